serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor computing DIFF = A - B - bi, LSB first, one bit per clock through a single full-subtractor cell plus a borrow flip-flop.
- It is the inverse-direction counterpart to the combinational ripple-carry adder datapath.
- It sits between a requester and a consumer, with a valid/ready handshake on each side.
- It trades area for latency: one cell instead of WIDTH cells.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request: A, B, bi are valid.
- in_ready  output  1  block can accept a request.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- bi  input  1  borrow in.
- out_valid  output  1  DIFF and bo are valid.
- out_ready  input  1  consumer accepts the result.
- DIFF  output  WIDTH  difference, modulo 2^WIDTH.
- bo  output  1  borrow out; 1 when A < B + bi (unsigned).

Behaviour:
- Reset: rst_n low asynchronously forces:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - DIFF = 0
  - bo = 0
  - bit counter = 0
  - borrow flop = 0
  - operand shift registers = 0
- Reset may assert in any state; any in-flight operation is discarded and no result is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On the edge where in_valid & in_ready, latch A and B into shift registers, latch bi into the borrow flop, clear the counter, and go to SHIFT.
- SHIFT:
  - in_ready = 0, out_valid = 0.
  - Each edge feeds a = A_sr[0], b = B_sr[0], and the borrow flop to the cell.
  - The difference bit enters the result register at the MSB and the result register shifts right. A_sr and B_sr shift right. The borrow flop takes the cell's borrow out. The counter increments.
  - After the edge processing bit WIDTH-1 (counter == WIDTH-1), go to DONE.
- DONE:
  - out_valid = 1, in_ready = 0.
  - DIFF and bo are stable and held while out_ready = 0 (backpressure, unbounded).
  - On the edge where out_valid & out_ready, go to IDLE. out_valid drops and DIFF/bo keep their last values.
- Latency: a request accepted at edge k gives out_valid = 1 after edge k+WIDTH. Throughput is one result per WIDTH+2 cycles minimum; there is no overlap with the next request.
- Cell equations:
  - d = a ^ b ^ br
  - bout = (~a & b) | (~a & br) | (b & br)
- Arithmetic: {bo, DIFF} equals the (WIDTH+1)-bit value 2^WIDTH + A - B - bi, with bo inverted from that sum's top bit. In other words, bo = 1 exactly when the unsigned result wraps.
- Wrap-around: 0 - 0 - 1 yields DIFF = all ones, bo = 1.
- in_valid while in SHIFT or DONE is ignored, not queued. The requester must hold its request until in_ready.
- A, B, and bi may change freely after acceptance.
- No X propagation: every register is reset.

Decomposition:
- Package serial_sub_pkg holds:
  - the state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
  - the counter width, computed as $clog2(WIDTH)
- Sub-module full_subtractor is combinational: inputs a, b, bi; outputs d, bo. It is instantiated once for the bit cell.
- The FSM, counter, shift registers, and borrow flop live in serial_subtractor.

Test Plan:
- Reset, then idle: after rst_n rises, in_ready = 1, out_valid = 0, DIFF = 0, bo = 0 for 10 cycles with in_valid = 0.
- Basic: A=9, B=3, bi=0 accepted at edge k -> out_valid after edge k+4, DIFF=6, bo=0; out_ready=1 returns to IDLE the next edge.
- Borrow/wrap: A=3, B=9, bi=0 -> DIFF=10 (4'hA), bo=1. Also A=0, B=0, bi=1 -> DIFF=4'hF, bo=1.
- Backpressure and ignored input: A=15, B=1, bi=1 with out_ready=0 for 7 cycles -> DIFF=13, bo=0 held constant. During SHIFT/DONE, in_valid=1 with A=2 causes no change. Result is consumed when out_ready rises.
- Reset mid-operation: assert rst_n low two cycles into SHIFT -> outputs return to reset values immediately (asynchronously). No out_valid follows. The next request, A=8, B=8, bi=0, gives DIFF=0, bo=0.
- Random regression: 1000 random A, B, bi with random out_ready stalls, WIDTH=4 and WIDTH=8. Results are compared against the {bo, DIFF} reference model, with exact WIDTH-cycle latency checked.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bit counter only needs to reach WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bi, bo = borrow out.
// Purely combinational, zero latency, no flow control.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~a & bi) | (b & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor DIFF = A - B - bi, LSB first through one cell.
// Latency: WIDTH cycles from acceptance to out_valid; no request overlap.
// Backpressure: result held in DONE until out_ready; in_ready low while busy.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] DIFF,
  output logic             bo
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, diff_q;
  logic             br_q, bo_q;
  logic             cell_d, cell_bo;
  logic             accept, last_bit;

  full_subtractor u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .bi (br_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  assign accept   = in_valid & in_ready;
  assign last_bit = (state == SHIFT) && (cnt == LAST_BIT);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      diff_q <= '0;
      br_q   <= 1'b0;
      bo_q   <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      a_sr <= A;
      b_sr <= B;
      br_q <= bi;
    end else if (state == SHIFT) begin
      // Difference bits enter at the MSB so bit 0 lands at DIFF[0] after WIDTH shifts.
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      diff_q <= {cell_d, diff_q[WIDTH-1:1]};
      br_q   <= cell_bo;
      cnt    <= cnt + CW'(1);
      if (last_bit) bo_q <= cell_bo;
    end
  end

  assign DIFF = diff_q;
  assign bo   = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 and WIDTH=8.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;

  logic       v4, r4, ov4, ordy4, bi4, bo4;
  logic [3:0] a4, b4, d4;
  logic       v8, r8, ov8, ordy8, bi8, bo8;
  logic [7:0] a8, b8, d8;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] sb4[$];
  logic [8:0] sb8[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .A(a4), .B(b4), .bi(bi4),
    .out_valid(ov4), .out_ready(ordy4), .DIFF(d4), .bo(bo4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .A(a8), .B(b8), .bi(bi8),
    .out_valid(ov8), .out_ready(ordy8), .DIFF(d8), .bo(bo8)
  );

  // Reference: 2^W + A - B - bi, top bit inverted gives the borrow.
  function automatic logic [4:0] model4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    logic [4:0] s;
    s = 5'd16 + {1'b0, a} - {1'b0, b} - {4'd0, bin};
    return {~s[4], s[3:0]};
  endfunction

  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [8:0] s;
    s = 9'd256 + {1'b0, a} - {1'b0, b} - {8'd0, bin};
    return {~s[8], s[7:0]};
  endfunction

  // All tasks start and end at posedge+1.
  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    v4 = 1'b1; a4 = a; b4 = b; bi4 = bin;
    @(posedge clk); #1;
    v4 = 1'b0;
  endtask

  task automatic wait_ov4(output int lat);
    lat = 0;
    while (!ov4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume4();
    ordy4 = 1'b1;
    @(posedge clk); #1;
    ordy4 = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({r4, ov4, d4, bo4} !== {1'b1, 1'b0, 4'h0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_idle4 cyc %0d: rdy=%b vld=%b diff=%h bo=%b, want rdy=1 vld=0 diff=0 bo=0",
                 i, r4, ov4, d4, bo4);
      end
    end
    n_tests++;
    if ({r8, ov8, d8, bo8} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_idle8: rdy=%b vld=%b diff=%h bo=%b", r8, ov8, d8, bo8);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [4:0] exp;
    send4(4'd9, 4'd3, 1'b0);
    sb4.push_back(5'b0_0110);
    wait_ov4(lat);
    n_tests++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d want 4", lat);
    end
    exp = sb4.pop_front();
    n_tests++;
    if ({bo4, d4} !== exp) begin
      n_fail++;
      $display("FAIL basic_result: got bo=%b diff=%0d want bo=%b diff=%0d", bo4, d4, exp[4], exp[3:0]);
    end
    consume4();
    n_tests++;
    if ({ov4, r4, d4} !== {1'b0, 1'b1, 4'd6}) begin
      n_fail++;
      $display("FAIL basic_return_idle: vld=%b rdy=%b diff=%0d want vld=0 rdy=1 diff=6", ov4, r4, d4);
    end
  endtask

  task automatic test_borrow();
    logic [3:0] ta[2]  = '{4'd3, 4'd0};
    logic [3:0] tb_[2] = '{4'd9, 4'd0};
    logic       tbi[2] = '{1'b0, 1'b1};
    logic [4:0] texp[2] = '{5'b1_1010, 5'b1_1111};
    int lat;
    logic [4:0] exp;
    for (int i = 0; i < 2; i++) begin
      send4(ta[i], tb_[i], tbi[i]);
      sb4.push_back(texp[i]);
      wait_ov4(lat);
      exp = sb4.pop_front();
      n_tests++;
      if (lat !== 4 || {bo4, d4} !== exp) begin
        n_fail++;
        $display("FAIL borrow_case%0d: lat=%0d bo=%b diff=%h want lat=4 bo=%b diff=%h",
                 i, lat, bo4, d4, exp[4], exp[3:0]);
      end
      consume4();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [4:0] exp;
    send4(4'd15, 4'd1, 1'b1);
    sb4.push_back(5'b0_1101);
    v4 = 1'b1; a4 = 4'd2; b4 = 4'd0; bi4 = 1'b0;
    n_tests++;
    if (r4 !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_in_ready: got %b want 0", r4);
    end
    wait_ov4(lat);
    n_tests++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d want 4", lat);
    end
    exp = sb4.pop_front();
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if ({ov4, r4, bo4, d4} !== {1'b1, 1'b0, exp}) begin
        n_fail++;
        $display("FAIL bp_hold cyc %0d: vld=%b rdy=%b bo=%b diff=%0d want vld=1 rdy=0 bo=%b diff=%0d",
                 i, ov4, r4, bo4, d4, exp[4], exp[3:0]);
      end
      @(posedge clk); #1;
    end
    v4 = 1'b0;
    consume4();
    n_tests++;
    if ({ov4, r4, bo4, d4} !== {1'b0, 1'b1, exp}) begin
      n_fail++;
      $display("FAIL bp_consume: vld=%b rdy=%b bo=%b diff=%0d want vld=0 rdy=1 bo=%b diff=%0d",
               ov4, r4, bo4, d4, exp[4], exp[3:0]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    logic [4:0] exp;
    send4(4'd5, 4'd3, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({r4, ov4, d4, bo4} !== {1'b1, 1'b0, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%b vld=%b diff=%h bo=%b want rdy=1 vld=0 diff=0 bo=0", r4, ov4, d4, bo4);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ov4) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_no_result: out_valid seen %0d cycles want 0", seen);
    end
    send4(4'd8, 4'd8, 1'b0);
    sb4.push_back(model4(4'd8, 4'd8, 1'b0));
    wait_ov4(lat);
    exp = sb4.pop_front();
    n_tests++;
    if (lat !== 4 || {bo4, d4} !== exp) begin
      n_fail++;
      $display("FAIL post_reset: lat=%0d bo=%b diff=%0d want lat=4 bo=%b diff=%0d", lat, bo4, d4, exp[4], exp[3:0]);
    end
    consume4();
  endtask

  task automatic rand4(input int n);
    int lat;
    int stall;
    logic [4:0] exp;
    logic [3:0] a, b;
    logic bin;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
      send4(a, b, bin);
      sb4.push_back(model4(a, b, bin));
      wait_ov4(lat);
      n_tests++;
      if (lat !== 4) begin
        n_fail++;
        $display("FAIL rand4_latency #%0d: got %0d want 4", i, lat);
      end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin @(posedge clk); #1; end
      exp = sb4.pop_front();
      n_tests++;
      if ({ov4, bo4, d4} !== {1'b1, exp}) begin
        n_fail++;
        $display("FAIL rand4_result #%0d: A=%0d B=%0d bi=%b vld=%b bo=%b diff=%0d want bo=%b diff=%0d",
                 i, a, b, bin, ov4, bo4, d4, exp[4], exp[3:0]);
      end
      consume4();
      n_tests++;
      if (ov4 !== 1'b0) begin
        n_fail++;
        $display("FAIL rand4_drop #%0d: out_valid=%b want 0", i, ov4);
      end
    end
  endtask

  task automatic rand8(input int n);
    int lat;
    int stall;
    logic [8:0] exp;
    logic [7:0] a, b;
    logic bin;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      n_tests++;
      if (r8 !== 1'b1) begin
        n_fail++;
        $display("FAIL rand8_in_ready #%0d: got %b want 1", i, r8);
      end
      v8 = 1'b1; a8 = a; b8 = b; bi8 = bin;
      @(posedge clk); #1;
      v8 = 1'b0;
      sb8.push_back(model8(a, b, bin));
      lat = 0;
      while (!ov8 && lat < 30) begin @(posedge clk); #1; lat++; end
      n_tests++;
      if (lat !== 8) begin
        n_fail++;
        $display("FAIL rand8_latency #%0d: got %0d want 8", i, lat);
      end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin @(posedge clk); #1; end
      exp = sb8.pop_front();
      n_tests++;
      if ({ov8, bo8, d8} !== {1'b1, exp}) begin
        n_fail++;
        $display("FAIL rand8_result #%0d: A=%0d B=%0d bi=%b vld=%b bo=%b diff=%0d want bo=%b diff=%0d",
                 i, a, b, bin, ov8, bo8, d8, exp[8], exp[7:0]);
      end
      ordy8 = 1'b1;
      @(posedge clk); #1;
      ordy8 = 1'b0;
    end
  endtask

  task automatic test_random();
    fork
      rand4(1000);
      rand8(1000);
    join
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    v4 = 1'b0; a4 = '0; b4 = '0; bi4 = 1'b0; ordy4 = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; bi8 = 1'b0; ordy8 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_basic();
    test_borrow();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
